// File: rtl/pla_stream_sequencer.sv
// pla_stream_sequencer
//   Initiator side of the pla activation interface. One job moves VEC_LEN fp32
//   pre-activation words from an upstream valid/ready stream into pla, one word
//   per cycle. Results come back from pla with fixed latency and no
//   backpressure. They land in a credit-protected FIFO and are replayed in
//   order to a downstream valid/ready consumer, with m_last on the final word.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start, gate_sel   job start pulse (accepted only in IDLE) and gate id
//                     (0=i, 1=f, 2=g, 3=o)
//   busy, done        job in progress / one-cycle completion pulse
//   s_valid, s_ready, s_data                     upstream word stream
//   pla_select, pla_valid_in, pla_valid_in_rev, pla_x   request side of pla
//   pla_valid_out, pla_out                       result side of pla
//   m_valid, m_ready, m_data, m_last             downstream result stream
module pla_stream_sequencer #(
  parameter int VEC_LEN    = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  gate_sel,
  output logic        busy,
  output logic        done,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        pla_select,
  output logic        pla_valid_in,
  output logic        pla_valid_in_rev,
  output logic [31:0] pla_x,
  input  logic        pla_valid_out,
  input  logic [31:0] pla_out,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CRD_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] VEC_END  = CNT_W'(VEC_LEN);
  localparam logic [CNT_W-1:0] VEC_LAST = CNT_W'(VEC_LEN - 1);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_reg;
  logic              busy_reg, done_reg, pla_select_reg;
  logic [CNT_W-1:0]  issue_cnt_reg, issue_cnt_next;
  logic [CNT_W-1:0]  out_cnt_reg, out_cnt_next;
  logic [CRD_W-1:0]  credits_reg, credits_next;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]    wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]    rd_ptr_reg, rd_ptr_next;
  logic [31:0]       mem [FIFO_DEPTH];
  logic              m_valid_reg;
  logic [31:0]       m_data_reg, head_next;
  logic              fifo_full, issue, push, pop;

  assign fifo_full = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

  // Issue path is combinational so a word accepted upstream reaches pla in
  // the same cycle.
  assign s_ready = (state_reg == RUN) && (issue_cnt_reg < VEC_END) &&
                   (credits_reg != '0);
  assign issue   = s_valid && s_ready;
  assign push    = pla_valid_out && !fifo_full;
  assign pop     = m_valid_reg && m_ready;

  assign pla_x            = issue ? s_data : 32'd0;
  assign pla_valid_in     = issue;
  assign pla_valid_in_rev = issue;
  assign pla_select       = pla_select_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign m_valid          = m_valid_reg;
  assign m_data           = m_data_reg;
  assign m_last           = m_valid_reg && (out_cnt_reg == VEC_LAST);

  assign issue_cnt_next = issue_cnt_reg + CNT_W'(issue);
  assign out_cnt_next   = out_cnt_reg + CNT_W'(pop);
  assign wr_ptr_next    = wr_ptr_reg + (PTR_W+1)'(push);
  assign rd_ptr_next    = rd_ptr_reg + (PTR_W+1)'(pop);

  // Credits track issued-but-not-popped words. Pops of results that were
  // never issued (leftovers around a reset) must not push credits past
  // FIFO_DEPTH, hence the saturation.
  always_comb begin
    credits_next = credits_reg;
    if (issue && !pop) begin
      credits_next = credits_reg - CRD_W'(1);
    end else if (pop && !issue && (credits_reg != CRD_MAX)) begin
      credits_next = credits_reg + CRD_W'(1);
    end
  end

  // Next head of the FIFO, loaded into the output register. When the FIFO
  // empties and refills in the same cycle, the head is the word being
  // written, so it comes from pla_out; it still shows up only next cycle.
  always_comb begin
    head_next = 32'd0;
    if (wr_ptr_next != rd_ptr_next) begin
      if (push && (wr_ptr_reg == rd_ptr_next)) begin
        head_next = pla_out;
      end else begin
        head_next = mem[rd_ptr_next[PTR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[PTR_W-1:0]] <= pla_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      pla_select_reg <= 1'b1;
      issue_cnt_reg  <= '0;
      out_cnt_reg    <= '0;
      credits_reg    <= CRD_MAX;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      m_valid_reg    <= 1'b0;
      m_data_reg     <= 32'd0;
    end else begin
      credits_reg   <= credits_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      m_valid_reg   <= (wr_ptr_next != rd_ptr_next);
      m_data_reg    <= head_next;
      issue_cnt_reg <= issue_cnt_next;
      out_cnt_reg   <= out_cnt_next;
      done_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            pla_select_reg <= (gate_sel != 2'd2);
            busy_reg       <= 1'b1;
            issue_cnt_reg  <= '0;
            out_cnt_reg    <= '0;
            state_reg      <= RUN;
          end
        end
        RUN: begin
          if (issue_cnt_next == VEC_END) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave on the cycle of the final pop so done follows m_last by one.
          if (out_cnt_next == VEC_END) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Credits should make this impossible; a hit means a result was dropped.
  fifo_overflow_check: assert property (@(posedge clk) disable iff (!reset)
                                        !(pla_valid_out && fifo_full));

endmodule

// File: tb/tb_pla_stream_sequencer.sv
// Testbench for pla_stream_sequencer with a fixed-latency pla stand-in.
module tb_pla_stream_sequencer;

  localparam int VEC_LEN    = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 6;
  localparam int PLA_LAT    = 3;

  logic        clk, rst_n, start;
  logic [1:0]  gate_sel;
  logic        busy, done, s_valid, s_ready;
  logic [31:0] s_data;
  logic        pla_select, pla_valid_in, pla_valid_in_rev;
  logic [31:0] pla_x;
  logic        pla_valid_out;
  logic [31:0] pla_out;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;

  int n_tests = 0;
  int n_fail  = 0;

  pla_stream_sequencer #(.VEC_LEN(VEC_LEN), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n), .start(start), .gate_sel(gate_sel),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .pla_select(pla_select), .pla_valid_in(pla_valid_in),
    .pla_valid_in_rev(pla_valid_in_rev), .pla_x(pla_x),
    .pla_valid_out(pla_valid_out), .pla_out(pla_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pla stand-in: the two reference points of the activation curves, and a
  // select-dependent scramble for everything else so order errors show.
  function automatic logic [31:0] pla_f(input logic [31:0] x, input logic sel);
    if (sel && x == 32'h3f800000) return 32'h3f347ae1;
    if (!sel && x == 32'hc0000000) return 32'h3e09374c;
    return x ^ (sel ? 32'h5a5a5a5a : 32'ha5a5a5a5);
  endfunction

  logic [PLA_LAT-1:0] pv;
  logic [31:0]        px [PLA_LAT];
  logic               ps [PLA_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
    end else begin
      pv    <= {pv[PLA_LAT-2:0], pla_valid_in};
      px[0] <= pla_x;
      ps[0] <= pla_select;
      for (int i = 1; i < PLA_LAT; i++) begin
        px[i] <= px[i-1];
        ps[i] <= ps[i-1];
      end
    end
  end
  assign pla_valid_out = pv[PLA_LAT-1];
  assign pla_out = pv[PLA_LAT-1] ? pla_f(px[PLA_LAT-1], ps[PLA_LAT-1]) : 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {25'd0, busy, done, s_ready, pla_valid_in, pla_valid_in_rev,
                           m_valid, m_last}, 32'd0);
    check({tag, "_pla_x"}, pla_x, 32'd0);
    check({tag, "_m_data"}, m_data, 32'd0);
    check({tag, "_sel"}, {31'd0, pla_select}, 32'd1);
  endtask

  typedef struct {
    logic [1:0]  gate;     // gate_sel at start
    logic [31:0] base;     // word i = base + step*i
    logic [31:0] step;
    int          s_gap;    // % of cycles with s_valid low
    int          m_gap;    // % of cycles with m_ready low
    int          m_hold;   // m_ready forced low for this many cycles first
    bit          spam;     // pulse start with another gate during the job
    logic        exp_sel;  // expected pla_select for the whole job
  } job_t;

  job_t jobs[6];

  task automatic run_job(input job_t j, input string tag);
    int in_i = 0, out_i = 0, done_cnt = 0, cyc = 0;
    int first_issue = -1, first_mv = -1, last_pop = -1, done_cyc = -1;
    logic [31:0] exp;
    @(posedge clk); #1;
    start = 1'b1; gate_sel = j.gate;
    @(posedge clk); #1;
    start = 1'b0; gate_sel = j.gate ^ 2'b10;
    while (cyc < 3000 && !(done_cnt > 0 && cyc > done_cyc + 3)) begin
      s_valid = (in_i < VEC_LEN) && ($urandom_range(99) >= j.s_gap);
      s_data  = j.base + j.step * in_i;
      m_ready = (cyc >= j.m_hold) && ($urandom_range(99) >= j.m_gap);
      start   = j.spam && (out_i < VEC_LEN) && (cyc % 5 == 2);
      @(negedge clk);
      if (s_valid && s_ready) begin
        check({tag, "_pla_x"}, pla_x, s_data);
        check({tag, "_strobes"}, {30'd0, pla_valid_in, pla_valid_in_rev}, 32'd3);
        check({tag, "_select"}, {31'd0, pla_select}, {31'd0, j.exp_sel});
        if (first_issue < 0) first_issue = cyc;
        in_i++;
      end else begin
        check({tag, "_idle_pla"}, pla_x | {31'd0, pla_valid_in | pla_valid_in_rev}, 32'd0);
      end
      if (j.m_hold > 0 && cyc == j.m_hold - 1) begin
        check({tag, "_held_issues"}, 32'(in_i), 32'(FIFO_DEPTH));
        check({tag, "_held_s_ready"}, {31'd0, s_ready}, 32'd0);
      end
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (m_valid && m_ready) begin
        exp = pla_f(j.base + j.step * out_i, j.exp_sel);
        check({tag, "_m_data"}, m_data, exp);
        check({tag, "_m_last"}, {31'd0, m_last}, {31'd0, out_i == VEC_LEN - 1});
        out_i++;
        last_pop = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_issued"}, 32'(in_i), 32'(VEC_LEN));
    check({tag, "_popped"}, 32'(out_i), 32'(VEC_LEN));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_after_last"}, 32'(done_cyc - last_pop), 32'd1);
    @(negedge clk);
    check({tag, "_end_busy_ready"}, {30'd0, busy, s_ready}, 32'd0);
    if (j.s_gap == 0 && j.m_gap == 0 && j.m_hold == 0) begin
      check({tag, "_first_latency"}, 32'(first_mv - first_issue), 32'(PLA_LAT + 1));
    end
    $display("[TB] %s: gate=%0d issued=%0d popped=%0d done_pulses=%0d",
             tag, j.gate, in_i, out_i, done_cnt);
  endtask

  initial begin
    int n_iss;
    jobs[0] = '{2'd0, 32'h3f800000, 32'd0, 0,  0,  0,  1'b0, 1'b1};
    jobs[1] = '{2'd2, 32'hc0000000, 32'd0, 0,  0,  0,  1'b0, 1'b0};
    jobs[2] = '{2'd1, 32'h40000000, 32'd1, 30, 40, 0,  1'b0, 1'b1};
    jobs[3] = '{2'd3, 32'h12340000, 32'd7, 0,  0,  20, 1'b0, 1'b1};
    jobs[4] = '{2'd2, 32'h00abc000, 32'd3, 20, 20, 0,  1'b1, 1'b0};
    jobs[5] = '{2'd0, 32'h3e000000, 32'd5, 10, 10, 0,  1'b1, 1'b1};

    start = 1'b0; gate_sel = 2'd0; s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      run_job(jobs[k], $sformatf("job%0d", k));
    end

    // Reset in the middle of a job after 10 issues.
    @(posedge clk); #1;
    start = 1'b1; gate_sel = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    n_iss = 0;
    for (int c = 0; c < 200 && n_iss < 10; c++) begin
      s_valid = 1'b1; s_data = 32'h7000_0000 + n_iss; m_ready = 1'b1;
      @(negedge clk);
      if (s_valid && s_ready) n_iss++;
      @(posedge clk); #1;
    end
    check("midjob_issues", 32'(n_iss), 32'd10);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midjob_reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("flushed_m_valid", {31'd0, m_valid}, 32'd0);
    check("flushed_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    run_job(jobs[5], "job5_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
